mp_exec_sequencer: RTL and testbench
====================================

Name: mp_exec_sequencer

Overview:
- Instruction sequencer for the bus-attached mini processor.
- After a start command (control register write of 1 at 0x0120), it steps through the instruction register file entries 0..NUM_INST-1.
- For each instruction it decodes opcode/Rd/Ra/Rb, steers the data register file read ports, and drives the ALU or the multi-cycle multiplier through its op_start/op_done handshake.
- It writes each result back to the data register file and raises an interrupt when the program completes.

Parameters:
- NUM_INST, 10: number of instructions executed per program (1..16).
- MUL_TIMEOUT, 64: max MUL_WAIT cycles before abort; used only with MP_SEQ_MUL_TIMEOUT_EN.

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse, decoded from control register write 0x0120 with data 1.
- irq_clear  input  1  acknowledges done_irq.
- inst_data  input  16  instruction word {op[15:12], Rd[11:8], Ra[7:4], Rb[3:0]} from the instruction RF; combinational read.
- mul_done  input  1  multiplier result valid.
- inst_addr  output  4  instruction RF read index, equal to pc.
- ra_addr  output  4  data RF read port 2 index.
- rb_addr  output  4  data RF read port 3 index.
- rd_addr  output  4  data RF write index.
- wb_en  output  1  data RF write enable.
- wb_sel  output  1  writeback source select: 0 = ALU (zero-extended to 64), 1 = MUL 64-bit.
- alu_op  output  4  ALU opcode.
- mul_start  output  1  multiplier op_start.
- mul_clear  output  1  multiplier op_clear.
- busy  output  1  high in any state other than IDLE and DONE.
- done_irq  output  1  completion interrupt, level.
- err  output  1  MUL timeout flag; constant 0 without the macro.
- pc  output  4  current instruction index.
- state  output  3  FSM state for debug.

Behaviour:
- Reset (asynchronous, effective immediately even mid-instruction): state = IDLE, pc = 0, IR = 0, done_irq = 0, err = 0, timeout counter = 0. All other outputs are 0.
- State encodings: IDLE = 0, FETCH = 1, EXEC = 2, MUL_WAIT = 3, WB = 4, DONE = 5.
- IDLE:
  - All control outputs are 0.
  - start = 1 → FETCH with pc = 0.
  - mul_done and irq_clear are ignored.
- FETCH:
  - inst_addr = pc.
  - IR <= inst_data at the clock edge; → EXEC.
- EXEC:
  - ra_addr = IR[7:4], rb_addr = IR[3:0], alu_op = IR[15:12], rd_addr = IR[11:8].
  - op 0000–0111 (ALU): → WB.
  - op 1000 (MUL): mul_clear = 1 for this cycle; → MUL_WAIT.
  - op 1001–1111 (NOP): → WB with writeback suppressed.
- MUL_WAIT:
  - ra_addr and rb_addr are held; mul_start is held at 1.
  - mul_done = 1 → WB; mul_start drops in WB.
- WB:
  - rd_addr = IR[11:8], wb_en = 1 for exactly one cycle; wb_en stays 0 for NOP.
  - wb_sel = 1 if op = 1000, else 0.
  - If pc = NUM_INST-1: → DONE and pc holds. Otherwise pc <= pc+1 and → FETCH.
- DONE:
  - done_irq is registered and equals 1 while in DONE.
  - irq_clear = 1 → IDLE with pc <= 0; done_irq falls on the same edge.
- Latency: an ALU or NOP instruction takes 3 cycles. A MUL instruction takes 3+L cycles, where L is the number of MUL_WAIT cycles until mul_done is sampled (L ≥ 1).
- Completion timing: for an all-ALU program, done_irq is first high after 3*NUM_INST rising edges following the edge that sampled start.
- start asserted in any state other than IDLE is ignored; there is no queuing.
- start and irq_clear asserted together in DONE: go to IDLE; start is dropped and must be re-pulsed.
- mul_done sampled outside MUL_WAIT is ignored.
- pc never wraps past NUM_INST-1.
- Only the low 4 bits of the register fields are used; the 0x010x base address is added by the register file wrapper.

Optional Feature:
- Macro: MP_SEQ_MUL_TIMEOUT_EN.
- When defined:
  - A counter runs in MUL_WAIT. It is cleared on entry and compared against MUL_TIMEOUT.
  - Reaching MUL_TIMEOUT cycles without mul_done: mul_clear = 1 for one cycle, err is set to 1, wb_en is suppressed, and the FSM goes to DONE (done_irq = 1).
  - err is sticky until irq_clear or reset.
- When not defined: MUL_WAIT waits indefinitely, err is tied to 0, and no counter logic is present.

Test Plan:
- 10 ALU instructions (e.g. 0x0312 = ADD R3 ← R1,R2), start pulse → wb_en pulses every 3 cycles with rd_addr matching IR[11:8]; done_irq high exactly 30 edges after start; pc = 9.
- Instruction 0x8512, mul_done driven 4 cycles after mul_start rises → mul_clear is a 1-cycle pulse in EXEC; mul_start high 4 cycles; wb_en with wb_sel = 1, rd_addr = 5; instruction takes 7 cycles.
- Program containing NOP opcode 0xF000 → no wb_en on that slot; pc still advances; total cycle count unchanged.
- start re-pulsed mid-program, plus stray mul_done during an ALU EXEC → no restart, no state change; program completes normally.
- Reset_n low during MUL_WAIT → state = 0, pc = 0, mul_start = 0 immediately; after release, a new start runs the program from index 0.
- With MP_SEQ_MUL_TIMEOUT_EN, MUL_TIMEOUT = 8, mul_done never asserted → after 8 MUL_WAIT cycles: mul_clear pulse, err = 1, done_irq = 1, no wb_en. irq_clear → IDLE, err = 0.

Source files
------------

// File: rtl/mp_exec_sequencer.sv
// mp_exec_sequencer
// Instruction sequencer for the bus-attached mini processor. A start pulse
// walks instruction entries 0..NUM_INST-1 through FETCH/EXEC/(MUL_WAIT)/WB,
// steering the data RF ports and the multiplier handshake, then raises
// done_irq until it is acknowledged with irq_clear.
// Optional build macro: MP_SEQ_MUL_TIMEOUT_EN adds a MUL_WAIT watchdog that
// aborts the program after MUL_TIMEOUT cycles and sets the sticky err flag.
// All control outputs are registered: they are decoded from the next state
// so they line up with the state they belong to.
module mp_exec_sequencer #(
  parameter int NUM_INST    = 10,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        irq_clear,
  input  logic [15:0] inst_data,
  input  logic        mul_done,
  output logic [3:0]  inst_addr,
  output logic [3:0]  ra_addr,
  output logic [3:0]  rb_addr,
  output logic [3:0]  rd_addr,
  output logic        wb_en,
  output logic        wb_sel,
  output logic [3:0]  alu_op,
  output logic        mul_start,
  output logic        mul_clear,
  output logic        busy,
  output logic        done_irq,
  output logic        err,
  output logic [3:0]  pc,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_MUL_WAIT = 3'd3,
    S_WB       = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [3:0] LAST_PC = 4'(NUM_INST - 1);
  localparam logic [3:0] OP_MUL  = 4'b1000;

  // Reject configurations the 4-bit program counter cannot address.
  if ((NUM_INST < 1) || (NUM_INST > 16)) begin : g_num_inst_check
    $error("mp_exec_sequencer: NUM_INST must be 1..16");
  end
  if (MUL_TIMEOUT < 1) begin : g_mul_timeout_check
    $error("mp_exec_sequencer: MUL_TIMEOUT must be at least 1");
  end

  // Opcode 1000 is the multiplier; everything above it is a NOP.
  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MUL);
  endfunction

  // ALU ops 0000-0111 and MUL write back; NOPs 1001-1111 do not.
  function automatic logic writes_back(input logic [3:0] op);
    return (op <= OP_MUL);
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  pc_r, pc_s;
  logic [15:0] ir_r, ir_s;

  logic [3:0]  ra_addr_r, ra_addr_s;
  logic [3:0]  rb_addr_r, rb_addr_s;
  logic [3:0]  rd_addr_r, rd_addr_s;
  logic [3:0]  alu_op_r, alu_op_s;
  logic        wb_en_r, wb_en_s;
  logic        wb_sel_r, wb_sel_s;
  logic        mul_start_r, mul_start_s;
  logic        mul_clear_r, mul_clear_s;
  logic        busy_r, busy_s;
  logic        done_irq_r, done_irq_s;

`ifdef MP_SEQ_MUL_TIMEOUT_EN
  localparam int TW = $clog2(MUL_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MUL_TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt_r, tmo_cnt_s;
  logic          err_r, err_s;
  logic          tmo_hit_s;
`endif

  // Next-state, program counter and instruction register logic.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
`ifdef MP_SEQ_MUL_TIMEOUT_EN
    tmo_cnt_s = tmo_cnt_r;
    err_s     = err_r;
    tmo_hit_s = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_FETCH;
          pc_s    = 4'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        ir_s    = inst_data;
        state_s = S_EXEC;
      end
      S_EXEC: begin
        if (is_mul(ir_r[15:12])) begin
          state_s = S_MUL_WAIT;
`ifdef MP_SEQ_MUL_TIMEOUT_EN
          tmo_cnt_s = {TW{1'b0}};
`endif
        end else begin
          state_s = S_WB;
        end
      end
      S_MUL_WAIT: begin
        if (mul_done) begin
          state_s = S_WB;
`ifdef MP_SEQ_MUL_TIMEOUT_EN
        end else if (tmo_cnt_r == TMO_LAST) begin
          // Multiplier never answered: abandon the program.
          state_s   = S_DONE;
          err_s     = 1'b1;
          tmo_hit_s = 1'b1;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TW'(1);
`else
        end else begin
          state_s = S_MUL_WAIT;
`endif
        end
      end
      S_WB: begin
        if (pc_r == LAST_PC) begin
          state_s = S_DONE;
        end else begin
          pc_s    = pc_r + 4'd1;
          state_s = S_FETCH;
        end
      end
      S_DONE: begin
        if (irq_clear) begin
          state_s = S_IDLE;
          pc_s    = 4'd0;
`ifdef MP_SEQ_MUL_TIMEOUT_EN
          err_s   = 1'b0;
`endif
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        pc_s    = 4'd0;
      end
    endcase
  end

  // Decode the control outputs for the state being entered.
  always_comb begin
    ra_addr_s   = 4'd0;
    rb_addr_s   = 4'd0;
    rd_addr_s   = 4'd0;
    alu_op_s    = 4'd0;
    wb_en_s     = 1'b0;
    wb_sel_s    = 1'b0;
    mul_start_s = 1'b0;
    mul_clear_s = 1'b0;
    done_irq_s  = 1'b0;
    busy_s      = (state_s != S_IDLE) && (state_s != S_DONE);
    case (state_s)
      S_EXEC: begin
        ra_addr_s   = ir_s[7:4];
        rb_addr_s   = ir_s[3:0];
        rd_addr_s   = ir_s[11:8];
        alu_op_s    = ir_s[15:12];
        mul_clear_s = is_mul(ir_s[15:12]);
      end
      S_MUL_WAIT: begin
        ra_addr_s   = ir_s[7:4];
        rb_addr_s   = ir_s[3:0];
        rd_addr_s   = ir_s[11:8];
        alu_op_s    = ir_s[15:12];
        mul_start_s = 1'b1;
      end
      S_WB: begin
        // Operands stay on the read ports so the ALU result is valid here.
        ra_addr_s = ir_s[7:4];
        rb_addr_s = ir_s[3:0];
        rd_addr_s = ir_s[11:8];
        alu_op_s  = ir_s[15:12];
        wb_en_s   = writes_back(ir_s[15:12]);
        wb_sel_s  = is_mul(ir_s[15:12]);
      end
      S_DONE: begin
        done_irq_s = 1'b1;
`ifdef MP_SEQ_MUL_TIMEOUT_EN
        mul_clear_s = tmo_hit_s;
`endif
      end
      default: begin
        busy_s = (state_s != S_IDLE) && (state_s != S_DONE);
      end
    endcase
  end

  // State, program counter, instruction and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= S_IDLE;
      pc_r        <= 4'd0;
      ir_r        <= 16'd0;
      ra_addr_r   <= 4'd0;
      rb_addr_r   <= 4'd0;
      rd_addr_r   <= 4'd0;
      alu_op_r    <= 4'd0;
      wb_en_r     <= 1'b0;
      wb_sel_r    <= 1'b0;
      mul_start_r <= 1'b0;
      mul_clear_r <= 1'b0;
      busy_r      <= 1'b0;
      done_irq_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      ir_r        <= ir_s;
      ra_addr_r   <= ra_addr_s;
      rb_addr_r   <= rb_addr_s;
      rd_addr_r   <= rd_addr_s;
      alu_op_r    <= alu_op_s;
      wb_en_r     <= wb_en_s;
      wb_sel_r    <= wb_sel_s;
      mul_start_r <= mul_start_s;
      mul_clear_r <= mul_clear_s;
      busy_r      <= busy_s;
      done_irq_r  <= done_irq_s;
    end
  end

`ifdef MP_SEQ_MUL_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tmo_cnt_r <= {TW{1'b0}};
      err_r     <= 1'b0;
    end else begin
      tmo_cnt_r <= tmo_cnt_s;
      err_r     <= err_s;
    end
  end
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign inst_addr = pc_r;
  assign pc        = pc_r;
  assign state     = state_r;
  assign ra_addr   = ra_addr_r;
  assign rb_addr   = rb_addr_r;
  assign rd_addr   = rd_addr_r;
  assign alu_op    = alu_op_r;
  assign wb_en     = wb_en_r;
  assign wb_sel    = wb_sel_r;
  assign mul_start = mul_start_r;
  assign mul_clear = mul_clear_r;
  assign busy      = busy_r;
  assign done_irq  = done_irq_r;

endmodule

// File: tb/tb_mp_exec_sequencer.sv
// Self-checking bench for mp_exec_sequencer (default build). A reference
// schedule is computed from the instruction latency rules (3 cycles per
// ALU/NOP, 3+L per MUL) and every cycle of the run is compared against it.
module tb_mp_exec_sequencer;
  localparam int NUM_INST = 10;
  localparam int MAXN     = 256;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        irq_clear = 1'b0;
  logic        mul_done = 1'b0;
  logic [15:0] inst_data;
  logic [3:0]  inst_addr, ra_addr, rb_addr, rd_addr, alu_op, pc;
  logic        wb_en, wb_sel, mul_start, mul_clear, busy, done_irq, err;
  logic [2:0]  state;

  logic [15:0] prog [16];
  int          lat  [16];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference schedule, indexed by edges since the start-sampling edge.
  int         total;
  logic [3:0] pc_exp  [MAXN];
  logic [3:0] rd_exp  [MAXN];
  bit         sel_exp [MAXN];
  bit         ms_exp  [MAXN];
  bit         clr_exp [MAXN];
  bit         wb_exp  [MAXN];
  bit         md_plan [MAXN];
  bit         in_mw   [MAXN];

  mp_exec_sequencer #(.NUM_INST(NUM_INST), .MUL_TIMEOUT(64)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .irq_clear(irq_clear),
    .inst_data(inst_data), .mul_done(mul_done), .inst_addr(inst_addr),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr), .wb_en(wb_en),
    .wb_sel(wb_sel), .alu_op(alu_op), .mul_start(mul_start),
    .mul_clear(mul_clear), .busy(busy), .done_irq(done_irq), .err(err),
    .pc(pc), .state(state)
  );

  always #5 Clk = ~Clk;

  // Instruction register file: combinational read.
  assign inst_data = prog[inst_addr];

  task automatic build_schedule();
    int s, l, len;
    logic [3:0] op;
    for (int k = 0; k < MAXN; k++) begin
      pc_exp[k] = 4'd0; rd_exp[k] = 4'd0; sel_exp[k] = 1'b0; ms_exp[k] = 1'b0;
      clr_exp[k] = 1'b0; wb_exp[k] = 1'b0; md_plan[k] = 1'b0; in_mw[k] = 1'b0;
    end
    s = 0;
    for (int i = 0; i < NUM_INST; i++) begin
      op  = prog[i][15:12];
      l   = (op == 4'd8) ? lat[i] : 0;
      len = 3 + l;
      for (int k = 0; k < len; k++) begin
        pc_exp[s+k]  = 4'(i);
        rd_exp[s+k]  = prog[i][11:8];
        sel_exp[s+k] = (op == 4'd8);
        ms_exp[s+k]  = (op == 4'd8) && (k >= 2) && (k <= 1 + l);
        in_mw[s+k]   = ms_exp[s+k];
        clr_exp[s+k] = (op == 4'd8) && (k == 1);
        md_plan[s+k] = (op == 4'd8) && (k == 1 + l);
        wb_exp[s+k]  = (k == len - 1) && (op <= 4'd8);
      end
      s += len;
    end
    total = s;
  endtask

  task automatic fill_random(input bit allow_mul_nop);
    logic [3:0] op;
    for (int i = 0; i < 16; i++) begin
      op = allow_mul_nop ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      prog[i] = (i < NUM_INST) ? {op, 12'($urandom)} : 16'h0000;
      lat[i]  = int'($urandom_range(1, 5));
    end
  endtask

  // Pulse start, follow the whole program cycle by cycle, optionally ack.
  task automatic run_program(input bit strays, input bit do_clear);
    bit         e_busy, e_irq, e_wb, e_ms, e_clr;
    logic [3:0] e_pc;
    build_schedule();
    mul_done = 1'b0;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int n = 0; n <= total + 1; n++) begin
      e_busy = (n < total);
      e_irq  = (n >= total);
      e_pc   = (n < total) ? pc_exp[n] : 4'(NUM_INST - 1);
      e_wb   = (n < total) && wb_exp[n];
      e_ms   = (n < total) && ms_exp[n];
      e_clr  = (n < total) && clr_exp[n];
      n_checks++;
      if (busy !== e_busy) $display("FAIL busy n=%0d got %b exp %b", n, busy, e_busy); else n_pass++;
      n_checks++;
      if (done_irq !== e_irq) $display("FAIL done_irq n=%0d got %b exp %b", n, done_irq, e_irq); else n_pass++;
      n_checks++;
      if (pc !== e_pc) $display("FAIL pc n=%0d got %0d exp %0d", n, pc, e_pc); else n_pass++;
      n_checks++;
      if (inst_addr !== e_pc) $display("FAIL inst_addr n=%0d got %0d exp %0d", n, inst_addr, e_pc); else n_pass++;
      n_checks++;
      if (wb_en !== e_wb) $display("FAIL wb_en n=%0d got %b exp %b", n, wb_en, e_wb); else n_pass++;
      n_checks++;
      if (mul_start !== e_ms) $display("FAIL mul_start n=%0d got %b exp %b", n, mul_start, e_ms); else n_pass++;
      n_checks++;
      if (mul_clear !== e_clr) $display("FAIL mul_clear n=%0d got %b exp %b", n, mul_clear, e_clr); else n_pass++;
      n_checks++;
      if (err !== 1'b0) $display("FAIL err n=%0d got %b exp 0", n, err); else n_pass++;
      if (e_wb) begin
        n_checks++;
        if (rd_addr !== rd_exp[n]) $display("FAIL rd_addr n=%0d got %0d exp %0d", n, rd_addr, rd_exp[n]); else n_pass++;
        n_checks++;
        if (wb_sel !== sel_exp[n]) $display("FAIL wb_sel n=%0d got %b exp %b", n, wb_sel, sel_exp[n]); else n_pass++;
      end
      if (n >= total) begin
        n_checks++;
        if (state !== 3'd5) $display("FAIL done_state n=%0d got %0d exp 5", n, state); else n_pass++;
      end
      if (n < total) begin
        mul_done = md_plan[n] | (strays && !in_mw[n] && ($urandom_range(0, 2) == 0));
        start    = strays && ($urandom_range(0, 3) == 0);
      end else begin
        mul_done = 1'b0;
        start    = 1'b0;
      end
      @(posedge Clk); #1;
    end
    mul_done = 1'b0;
    start    = 1'b0;
    if (do_clear) begin
      irq_clear = 1'b1;
      @(posedge Clk); #1;
      irq_clear = 1'b0;
      n_checks++;
      if (state !== 3'd0) $display("FAIL clear_state got %0d exp 0", state); else n_pass++;
      n_checks++;
      if (done_irq !== 1'b0) $display("FAIL clear_irq got %b exp 0", done_irq); else n_pass++;
      n_checks++;
      if (pc !== 4'd0) $display("FAIL clear_pc got %0d exp 0", pc); else n_pass++;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #3;
    n_checks++;
    if (state !== 3'd0 || pc !== 4'd0) $display("FAIL reset_state got state=%0d pc=%0d exp 0/0", state, pc); else n_pass++;
    n_checks++;
    if ({wb_en, wb_sel, mul_start, mul_clear, busy, done_irq, err} !== 7'd0)
      $display("FAIL reset_ctrl got %b exp 0000000", {wb_en, wb_sel, mul_start, mul_clear, busy, done_irq, err});
    else n_pass++;
    n_checks++;
    if ({ra_addr, rb_addr, rd_addr, alu_op, inst_addr} !== 20'd0)
      $display("FAIL reset_addr got %h exp 0", {ra_addr, rb_addr, rd_addr, alu_op, inst_addr});
    else n_pass++;
    @(negedge Clk);
    Reset_n = 1'b1;
    // mul_done and irq_clear must not move the FSM out of IDLE.
    mul_done = 1'b1; irq_clear = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    mul_done = 1'b0; irq_clear = 1'b0;
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b0) $display("FAIL idle_ignore got state=%0d busy=%b exp 0/0", state, busy); else n_pass++;
  endtask

  task automatic test_alu_program();
    fill_random(1'b0);
    prog[0] = 16'h0312;
    run_program(1'b0, 1'b1);
  endtask

  task automatic test_mul();
    fill_random(1'b0);
    prog[0] = 16'h8512;
    lat[0]  = 4;
    prog[6] = 16'h8A3C;
    lat[6]  = 1;
    run_program(1'b0, 1'b1);
  endtask

  task automatic test_nop();
    fill_random(1'b0);
    prog[4] = 16'hF000;
    prog[9] = 16'h9123;
    run_program(1'b0, 1'b1);
  endtask

  task automatic test_stray_inputs();
    fill_random(1'b0);
    prog[2] = 16'h8456;
    lat[2]  = 3;
    run_program(1'b1, 1'b1);
  endtask

  task automatic test_random_programs();
    for (int r = 0; r < 4; r++) begin
      fill_random(1'b1);
      run_program(1'b1, 1'b1);
    end
  endtask

  task automatic test_reset_mid_mul();
    fill_random(1'b0);
    prog[0] = 16'h8512;
    lat[0]  = 4;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if (mul_start !== 1'b1 || state !== 3'd3) $display("FAIL pre_reset_mw got state=%0d mul_start=%b exp 3/1", state, mul_start); else n_pass++;
    #2;
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || pc !== 4'd0 || mul_start !== 1'b0)
      $display("FAIL async_reset got state=%0d pc=%0d mul_start=%b exp 0/0/0", state, pc, mul_start);
    else n_pass++;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    run_program(1'b0, 1'b1);
  endtask

  task automatic test_done_clear_with_start();
    fill_random(1'b1);
    run_program(1'b0, 1'b0);
    start = 1'b1; irq_clear = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0; irq_clear = 1'b0;
    n_checks++;
    if (state !== 3'd0 || done_irq !== 1'b0) $display("FAIL done_clear got state=%0d irq=%b exp 0/0", state, done_irq); else n_pass++;
    @(posedge Clk); #1;
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b0) $display("FAIL start_dropped got state=%0d busy=%b exp 0/0", state, busy); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      prog[i] = 16'h0000;
      lat[i]  = 1;
    end
    test_reset();
    test_alu_program();
    test_mul();
    test_nop();
    test_stray_inputs();
    test_random_programs();
    test_reset_mid_mul();
    test_done_clear_with_start();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
